// File: rtl/mvb_encode.sv
// mvb_encode: MVB Manchester frame encoder. Sends a start delimiter, data
// words, 7-bit CRC + parity check fields and an end delimiter.
// Ports: clk, rst (async, active-low); start, frame_type and frame_length
// request a frame; word_in, word_valid and word_ack fetch payload words;
// tx_out and tx_en drive the line; busy, frame_done, length_error and
// underrun_error report status.
module mvb_encode (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_type,
  input  logic [4:0]  frame_length,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ack,
  output logic        tx_out,
  output logic        tx_en,
  output logic        busy,
  output logic        frame_done,
  output logic        length_error,
  output logic        underrun_error
);
  typedef enum logic [2:0] {
    IDLE, DELIM, DATA, CHECK, ENDF
  } state_t;

  // Delimiter half-bits, first half-bit in the MSB.
  localparam logic [17:0] M_DEL = 18'b101100011100010101;
  localparam logic [17:0] S_DEL = 18'b101010001110001101;
  localparam logic [6:0]  POLY  = 7'b1100101;

  state_t      state, state_d;
  logic [3:0]  cyc, bitn;
  logic [4:0]  left;
  logic [1:0]  grp;
  logic        slave;
  logic [15:0] sreg;
  logic [6:0]  crc, crc_d;
  logic        par, par_d;
  logic [7:0]  chk;
  logic        done;

  logic       bit_end, half, dbit, legal;
  logic       go, bad, fetch, abort;
  logic       last_bit, to_check, lvl;
  logic [4:0] dix;

  assign bit_end  = cyc == 4'd15;
  assign half     = cyc[3];
  assign dbit     = sreg[4'd15 - bitn];
  assign dix      = 5'd17 - {bitn, half};
  assign legal    = !frame_type ||
    (frame_length inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16});
  assign go       = state == IDLE && start && legal;
  assign bad      = state == IDLE && start && !legal;
  assign to_check = left == 5'd0 || grp == 2'd3;
  assign crc_d    = {crc[5:0], 1'b0} ^
                    ((crc[6] ^ dbit) ? POLY : 7'd0);
  assign par_d    = par ^ dbit;

  always_comb begin
    last_bit = 1'b0;
    unique case (state)
      DELIM:   last_bit = bitn == 4'd8;
      DATA:    last_bit = bitn == 4'd15;
      CHECK:   last_bit = bitn == 4'd7;
      ENDF:    last_bit = 1'b1;
      default: last_bit = 1'b0;
    endcase
  end

  // A word is fetched on the last clk of the bit before its first bit.
  assign fetch = bit_end && last_bit && (
    state == DELIM ||
    (state == DATA && !to_check) ||
    (state == CHECK && left != 5'd0));
  assign abort    = fetch && !word_valid;
  assign word_ack = fetch && word_valid;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (go) state_d = DELIM;
      DELIM: if (bit_end && last_bit) state_d = DATA;
      DATA:
        if (bit_end && last_bit)
          state_d = to_check ? CHECK : DATA;
      CHECK:
        if (bit_end && last_bit)
          state_d = (left != 5'd0) ? DATA : ENDF;
      ENDF:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    lvl = 1'b0;
    unique case (state)
      DELIM:   lvl = slave ? S_DEL[dix] : M_DEL[dix];
      DATA:    lvl = dbit ^ half;
      CHECK:   lvl = ~chk[3'd7 - bitn[2:0]] ^ half;
      default: lvl = 1'b0;
    endcase
  end

  assign tx_en      = state != IDLE;
  assign busy       = state != IDLE;
  assign tx_out     = lvl;
  assign frame_done = done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc            <= '0;
      bitn           <= '0;
      left           <= '0;
      grp            <= '0;
      slave          <= 1'b0;
      sreg           <= '0;
      crc            <= '0;
      par            <= 1'b0;
      chk            <= '0;
      done           <= 1'b0;
      length_error   <= 1'b0;
      underrun_error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        cyc  <= '0;
        bitn <= '0;
      end else begin
        cyc <= cyc + 4'd1;
        if (bit_end)
          bitn <= last_bit ? 4'd0 : bitn + 4'd1;
      end
      if (go || bad) begin
        length_error   <= bad;
        underrun_error <= 1'b0;
      end
      if (bad) done <= 1'b1;
      if (go) begin
        slave <= frame_type;
        left  <= frame_type ? frame_length : 5'd1;
        grp   <= '0;
        crc   <= '0;
        par   <= 1'b0;
      end
      if (word_ack) begin
        sreg <= word_in;
        left <= left - 5'd1;
      end
      if (state == DATA && bit_end) begin
        crc <= crc_d;
        par <= par_d;
        if (last_bit) begin
          grp <= grp + 2'd1;
          if (to_check) begin
            // Parity covers data and CRC bits, so fold in ^crc_d.
            chk <= {crc_d, par_d ^ (^crc_d)};
            crc <= '0;
            par <= 1'b0;
            grp <= '0;
          end
        end
      end
      if (abort) begin
        underrun_error <= 1'b1;
        done           <= 1'b1;
      end
      if (state == ENDF && bit_end) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mvb_encode.sv
// tb_mvb_encode: randomized self-checking bench for mvb_encode
// against a half-bit level frame model.
module tb_mvb_encode;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        frame_type = 1'b0;
  logic [4:0]  frame_length = '0;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ack, tx_out, tx_en, busy;
  logic        frame_done, length_error, underrun_error;

  mvb_encode dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_type(frame_type), .frame_length(frame_length),
    .word_in(word_in), .word_valid(word_valid),
    .word_ack(word_ack), .tx_out(tx_out), .tx_en(tx_en),
    .busy(busy), .frame_done(frame_done),
    .length_error(length_error),
    .underrun_error(underrun_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [15:0] words [16];
  bit          eh [$];
  bit          msg [$];
  int          wbit [16];
  int          cpos [$];
  logic [7:0]  cval [$];
  logic        obs [8192];

  task automatic put_bit(input bit b);
    eh.push_back(b);
    eh.push_back(!b);
  endtask

  task automatic put_halves(input string s);
    for (int i = 0; i < s.len(); i++)
      eh.push_back(s[i] == "H");
  endtask

  // CRC by polynomial long division of msg * x^7, then parity.
  function automatic logic [7:0] check_byte();
    bit r [$];
    bit poly [8] = '{1, 1, 1, 0, 0, 1, 0, 1};
    logic [6:0] rem;
    int ones = 0;
    r = msg;
    for (int k = 0; k < 7; k++) r.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (r[i])
        for (int j = 0; j < 8; j++) r[i+j] = r[i+j] ^ poly[j];
    for (int k = 0; k < 7; k++) rem[6-k] = r[msg.size()+k];
    foreach (msg[i]) ones += int'(msg[i]);
    ones += $countones(rem);
    return {rem, 1'(ones % 2)};
  endfunction

  task automatic build_model(input bit ft, input int nw);
    logic [7:0] v;
    eh.delete(); cpos.delete(); cval.delete(); msg.delete();
    if (ft) put_halves("HLHLHLLLHHHLLLHHLH");
    else    put_halves("HLHHLLLHHHLLLHLHLH");
    for (int w = 0; w < nw; w++) begin
      wbit[w] = eh.size() / 2;
      for (int i = 15; i >= 0; i--) begin
        put_bit(words[w][i]);
        msg.push_back(words[w][i]);
      end
      if ((w % 4) == 3 || w == nw - 1) begin
        v = ~check_byte();
        cpos.push_back(eh.size() / 2);
        cval.push_back(v);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        msg.delete();
      end
    end
    put_halves("LL");
  endtask

  // Runs one frame; drop = index of the first word withheld,
  // poke = cycle on which a stray start is pulsed (0 = none).
  task automatic run_frame(input bit ft, input int nw,
                           input int drop, input int poke,
                           output int done_at,
                           output logic [7:0] chk0);
    int L, n_ack, werr, aerr, nexp;
    logic [7:0] got;
    build_model(ft, nw);
    L = (drop < nw) ? wbit[drop] * 16 : eh.size() * 8;
    nexp = (drop < nw) ? drop : nw;
    n_ack = 0; werr = 0; aerr = 0; done_at = -1; chk0 = 'x;
    @(posedge clk); #1;
    start = 1'b1;
    frame_type = ft;
    frame_length = ft ? nw[4:0] : 5'($urandom_range(0, 31));
    word_in = words[0];
    word_valid = drop > 0;
    for (int c = 1; c <= L + 2; c++) begin
      @(posedge clk); #1;
      start = (c == poke);
      if (c == poke) begin
        frame_type = 1'($urandom);
        frame_length = 5'($urandom);
      end
      word_in = (n_ack < 16) ? words[n_ack] : 16'($urandom);
      word_valid = n_ack < drop;
      #1;
      obs[c] = tx_out;
      if (c == 1 && length_error !== 1'b0) werr++;
      if (c <= L) begin
        if ({tx_en, busy, frame_done} !== 3'b110) werr++;
        if (tx_out !== eh[(c-1)/8]) werr++;
      end else if (c == L + 1) begin
        if ({tx_out, tx_en, busy} !== 3'b000) werr++;
      end
      if (word_ack === 1'b1) begin
        if (n_ack >= nw || c != wbit[n_ack] * 16) aerr++;
        n_ack++;
      end
      if (frame_done === 1'b1 && done_at < 0) done_at = c;
    end
    start = 1'b0;
    chk("wave", werr, 0);
    chk("done_at", done_at, L + 1);
    chk("acks", n_ack, nexp);
    chk("ack_time", aerr, 0);
    chk("underrun", underrun_error, drop < nw);
    chk("len_err", length_error, 0);
    for (int k = 0; k < cpos.size(); k++) begin
      if ((cpos[k] + 8) * 16 <= L) begin
        for (int i = 0; i < 8; i++)
          got[7-i] = obs[1 + 16 * (cpos[k] + i) + 3];
        chk("check_fld", got, cval[k]);
        if (k == 0) chk0 = got;
      end
    end
  endtask

  int         d;
  logic [7:0] c0;
  int         hits;
  bit         ft;
  int         nw;

  initial begin
    #1;
    chk("rst_outs", {tx_out, tx_en, busy, word_ack, frame_done,
                     length_error, underrun_error}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    words[0] = 16'h0000;
    run_frame(1'b0, 1, 99, 0, d, c0);
    chk("m0_done", d, 545);
    chk("m0_check", c0, 8'hFF);

    foreach (words[i]) words[i] = 16'($urandom);
    run_frame(1'b1, 8, 99, 0, d, c0);
    chk("s8_done", d, 2465);

    for (int it = 0; it < 6; it++) begin
      foreach (words[i]) words[i] = 16'($urandom);
      ft = 1'($urandom);
      nw = ft ? (1 << $urandom_range(0, 4)) : 1;
      run_frame(ft, nw, 99, 0, d, c0);
    end

    @(posedge clk); #1;
    start = 1'b1; frame_type = 1'b1; frame_length = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("le_flag", length_error, 1);
    chk("le_done", frame_done, 1);
    chk("le_txen", {tx_en, busy}, 0);
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (tx_en !== 1'b0 || frame_done !== 1'b0) hits++;
    end
    chk("le_quiet", hits, 0);
    chk("le_sticky", length_error, 1);

    foreach (words[i]) words[i] = 16'($urandom);
    run_frame(1'b1, 2, 1, 0, d, c0);
    run_frame(1'b1, 4, 99, 0, d, c0);

    foreach (words[i]) words[i] = 16'($urandom);
    run_frame(1'b1, 4, 99, 100, d, c0);
    run_frame(1'b0, 1, 99, 300, d, c0);

    // Reset during bit 20 of a master frame.
    words[0] = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b1; frame_type = 1'b0; word_in = words[0];
    word_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16 * 20 + 4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid", {tx_out, tx_en, busy, word_ack, frame_done,
                    length_error, underrun_error}, 0);
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      if (frame_done !== 1'b0) hits++;
    end
    chk("rst_nodone", hits, 0);
    #1 rst = 1'b1;
    run_frame(1'b0, 1, 99, 0, d, c0);
    chk("post_rst", d, 545);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
